// File: rtl/download_ddr_packer.sv
// Packs 16-bit HPS download words into byte-masked 64-bit DDR writes; a write issues the cycle after lane 3, a group change or download end.
// ioctl_wait is held high for as long as the DDR request is outstanding; ioctl_wr during that window is dropped.
module download_ddr_packer #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [15:0] ioctl_dout,
   output logic        ioctl_wait,
   output logic        ddr_wr,
   output logic [31:0] ddr_addr,
   output logic [63:0] ddr_din,
   output logic [7:0]  ddr_mask,
   output logic [7:0]  ddr_burst_count,
   input  logic        ddr_wait_req,
   output logic        done
);

   typedef enum logic {ACC, WRITE} state_t;

   state_t      state_q, state_d;
   logic [21:0] grp_q, grp_d;
   logic [63:0] din_d;
   logic [7:0]  mask_d;
   logic        addr_ld;

   logic        pend_vld_q, pend_vld_d;
   logic [15:0] pend_dat_q, pend_dat_d;
   logic [1:0]  pend_lane_q, pend_lane_d;
   logic [21:0] pend_grp_q, pend_grp_d;

   logic        dl_q, dl_seen_q, dl_rise;
   logic [1:0]  lane;
   logic [21:0] grp_in;
   logic        wr_ok;
   logic        addr_bit0_unused;

   assign lane             = ioctl_addr[2:1];
   assign grp_in           = ioctl_addr[24:3];
   assign wr_ok            = ioctl_wr & ~ioctl_wait;
   assign dl_rise          = ioctl_download & ~dl_q;
   assign addr_bit0_unused = ioctl_addr[0];
   assign ddr_burst_count  = 8'd1;

   function automatic logic [7:0] lane_mask(input logic [1:0] k);
      return 8'b11 << {k, 1'b0};
   endfunction

   always_comb begin
      state_d     = state_q;
      grp_d       = grp_q;
      din_d       = ddr_din;
      mask_d      = ddr_mask;
      addr_ld     = 1'b0;
      pend_vld_d  = pend_vld_q;
      pend_dat_d  = pend_dat_q;
      pend_lane_d = pend_lane_q;
      pend_grp_d  = pend_grp_q;

      case (state_q)
         ACC: begin
            if (wr_ok) begin
               if (ddr_mask == 8'h00) begin
                  din_d                    = 64'h0;
                  din_d[{lane, 4'h0} +: 16] = ioctl_dout;
                  mask_d                   = lane_mask(lane);
                  grp_d                    = grp_in;
                  addr_ld                  = 1'b1;
                  if (lane == 2'd3) state_d = WRITE;
               end else if (grp_in == grp_q) begin
                  din_d[{lane, 4'h0} +: 16] = ioctl_dout;
                  mask_d                   = ddr_mask | lane_mask(lane);
                  if (lane == 2'd3) state_d = WRITE;
               end else begin
                  // Flush the current group untouched; the new word waits in the pending slot.
                  state_d     = WRITE;
                  pend_vld_d  = 1'b1;
                  pend_dat_d  = ioctl_dout;
                  pend_lane_d = lane;
                  pend_grp_d  = grp_in;
               end
            end
            // Level-sensitive so a word reloaded from pending after download end still flushes.
            if (state_d == ACC && mask_d != 8'h00 && !ioctl_download) state_d = WRITE;
         end
         WRITE: begin
            if (!ddr_wait_req) begin
               state_d = ACC;
               din_d   = 64'h0;
               mask_d  = 8'h00;
               if (pend_vld_q) begin
                  din_d[{pend_lane_q, 4'h0} +: 16] = pend_dat_q;
                  mask_d                          = lane_mask(pend_lane_q);
                  grp_d                           = pend_grp_q;
                  addr_ld                         = 1'b1;
                  pend_vld_d                      = 1'b0;
                  if (pend_lane_q == 2'd3) state_d = WRITE;
               end
            end
         end
         default: state_d = ACC;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ACC;
         ddr_wr      <= 1'b0;
         ioctl_wait  <= 1'b0;
         ddr_din     <= 64'h0;
         ddr_mask    <= 8'h00;
         ddr_addr    <= 32'h0;
         grp_q       <= 22'h0;
         pend_vld_q  <= 1'b0;
         pend_dat_q  <= 16'h0;
         pend_lane_q <= 2'd0;
         pend_grp_q  <= 22'h0;
         dl_q        <= 1'b0;
         dl_seen_q   <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_d;
         ddr_wr      <= (state_d == WRITE);
         ioctl_wait  <= (state_d == WRITE);
         ddr_din     <= din_d;
         ddr_mask    <= mask_d;
         grp_q       <= grp_d;
         if (addr_ld) ddr_addr <= BASE_ADDR + {7'h0, grp_d, 3'b000};
         pend_vld_q  <= pend_vld_d;
         pend_dat_q  <= pend_dat_d;
         pend_lane_q <= pend_lane_d;
         pend_grp_q  <= pend_grp_d;
         dl_q        <= ioctl_download;
         dl_seen_q   <= dl_seen_q | dl_rise;
         if (dl_rise)
            done <= 1'b0;
         else if (dl_seen_q && !ioctl_download && state_q == ACC &&
                  ddr_mask == 8'h00 && !pend_vld_q)
            done <= 1'b1;
      end
   end

endmodule
